// File: rtl/stopwatch_core_if.sv
// Bundle of the stopwatch's divider strobes, raw buttons and display/time outputs.
// The core connects through the slave modport; whatever drives the inputs uses master.
interface stopwatch_core_if;
  logic       clk_1Hz;
  logic       clk_1kHz;
  logic       btn_start_stop;
  logic       btn_clear;
  logic [6:0] seg;
  logic [3:0] an;
  logic       running;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic [1:0] dbg_state;

  modport master (
    output clk_1Hz, clk_1kHz, btn_start_stop, btn_clear,
    input  seg, an, running, sec_ones, sec_tens, min_ones, min_tens, dbg_state
  );

  modport slave (
    input  clk_1Hz, clk_1kHz, btn_start_stop, btn_clear,
    output seg, an, running, sec_ones, sec_tens, min_ones, min_tens, dbg_state
  );
endinterface

// File: rtl/stopwatch_core.sv
// Stopwatch core: tick extraction, button debounce, start/pause/clear FSM,
// MM:SS BCD counter and a 4-digit multiplexed active-low 7-segment driver.

module stopwatch_debounce #(
  parameter int TICKS = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ms_tick,
  input  logic raw,
  output logic press
);
  logic       sync1;
  logic       sync2;
  logic       stable;
  logic       stable_d;
  logic [4:0] cnt;

  // Any return of the synchronised level to `stable` restarts the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= 5'd0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_d <= stable;
      if (sync2 == stable) begin
        cnt <= 5'd0;
      end else if (ms_tick) begin
        if (cnt == 5'(TICKS - 1)) begin
          stable <= sync2;
          cnt    <= 5'd0;
        end else begin
          cnt <= cnt + 5'd1;
        end
      end
    end
  end

  assign press = stable & ~stable_d;
endmodule

module stopwatch_core #(
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic            clk_25MHz,
  input  logic            rst_n,
  stopwatch_core_if.slave bus
);
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2
  } state_t;

  // [0]/[1] synchroniser stages, [2] previous synchronised value.
  logic [2:0] hz_sh;
  logic [2:0] khz_sh;
  logic       tick_1hz;
  logic       tick_1khz;

  logic       ss_press;
  logic       clr_press;

  state_t     state_q;
  state_t     state_d;
  logic       running_q;
  logic       count_en;
  logic       clear_digits;

  logic [3:0] sec_ones_q;
  logic [3:0] sec_tens_q;
  logic [3:0] min_ones_q;
  logic [3:0] min_tens_q;

  logic [1:0] idx;
  logic [3:0] digit_sel;
  logic [3:0] an_next;
  logic [6:0] seg_next;
  logic [3:0] an_q;
  logic [6:0] seg_q;

  always_ff @(posedge clk_25MHz) begin
    if (!rst_n) begin
      hz_sh  <= 3'b000;
      khz_sh <= 3'b000;
    end else begin
      hz_sh  <= {hz_sh[1], hz_sh[0], bus.clk_1Hz};
      khz_sh <= {khz_sh[1], khz_sh[0], bus.clk_1kHz};
    end
  end

  assign tick_1hz  = hz_sh[1] & ~hz_sh[2];
  assign tick_1khz = khz_sh[1] & ~khz_sh[2];

  stopwatch_debounce #(.TICKS(DEBOUNCE_TICKS)) u_db_start_stop (
    .clk     (clk_25MHz),
    .rst_n   (rst_n),
    .ms_tick (tick_1khz),
    .raw     (bus.btn_start_stop),
    .press   (ss_press)
  );

  stopwatch_debounce #(.TICKS(DEBOUNCE_TICKS)) u_db_clear (
    .clk     (clk_25MHz),
    .rst_n   (rst_n),
    .ms_tick (tick_1khz),
    .raw     (bus.btn_clear),
    .press   (clr_press)
  );

  // FSM state register; running is registered alongside so both move on one edge.
  always_ff @(posedge clk_25MHz) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == ST_RUNNING);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_press)     state_d = ST_IDLE;
        else if (ss_press) state_d = ST_RUNNING;
      end
      ST_RUNNING: begin
        if (ss_press)      state_d = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (clr_press)     state_d = ST_IDLE;
        else if (ss_press) state_d = ST_RUNNING;
      end
      default:             state_d = ST_IDLE;
    endcase
  end

  // Counting follows the registered state, so a tick on the pause edge still counts.
  always_comb begin
    count_en     = 1'b0;
    clear_digits = 1'b0;
    case (state_q)
      ST_RUNNING:         count_en     = tick_1hz;
      ST_IDLE, ST_PAUSED: clear_digits = clr_press;
      default: begin
        count_en     = 1'b0;
        clear_digits = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_25MHz) begin
    if (!rst_n || clear_digits) begin
      sec_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      min_tens_q <= 4'd0;
    end else if (count_en) begin
      if (sec_ones_q == 4'd9) begin
        sec_ones_q <= 4'd0;
        if (sec_tens_q == 4'd5) begin
          sec_tens_q <= 4'd0;
          if (min_ones_q == 4'd9) begin
            min_ones_q <= 4'd0;
            if (min_tens_q == 4'd5) min_tens_q <= 4'd0;
            else                    min_tens_q <= min_tens_q + 4'd1;
          end else begin
            min_ones_q <= min_ones_q + 4'd1;
          end
        end else begin
          sec_tens_q <= sec_tens_q + 4'd1;
        end
      end else begin
        sec_ones_q <= sec_ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_25MHz) begin
    if (!rst_n) begin
      idx <= 2'd0;
    end else if (tick_1khz) begin
      idx <= idx + 2'd1;
    end
  end

  always_comb begin
    digit_sel = sec_ones_q;
    an_next   = 4'b1110;
    case (idx)
      2'd0: begin digit_sel = sec_ones_q; an_next = 4'b1110; end
      2'd1: begin digit_sel = sec_tens_q; an_next = 4'b1101; end
      2'd2: begin digit_sel = min_ones_q; an_next = 4'b1011; end
      2'd3: begin digit_sel = min_tens_q; an_next = 4'b0111; end
      default: begin digit_sel = sec_ones_q; an_next = 4'b1110; end
    endcase
  end

  // Active-low decode, seg[0]=a .. seg[6]=g.
  always_comb begin
    seg_next = 7'b1111111;
    case (digit_sel)
      4'd0: seg_next = 7'b1000000;
      4'd1: seg_next = 7'b1111001;
      4'd2: seg_next = 7'b0100100;
      4'd3: seg_next = 7'b0110000;
      4'd4: seg_next = 7'b0011001;
      4'd5: seg_next = 7'b0010010;
      4'd6: seg_next = 7'b0000010;
      4'd7: seg_next = 7'b1111000;
      4'd8: seg_next = 7'b0000000;
      4'd9: seg_next = 7'b0010000;
      default: seg_next = 7'b1111111;
    endcase
  end

  always_ff @(posedge clk_25MHz) begin
    if (!rst_n) begin
      an_q  <= 4'b1111;
      seg_q <= 7'b1111111;
    end else begin
      an_q  <= an_next;
      seg_q <= seg_next;
    end
  end

  assign bus.seg       = seg_q;
  assign bus.an        = an_q;
  assign bus.running   = running_q;
  assign bus.sec_ones  = sec_ones_q;
  assign bus.sec_tens  = sec_tens_q;
  assign bus.min_ones  = min_ones_q;
  assign bus.min_tens  = min_tens_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_stopwatch_core.sv
// Directed-plus-random bench for stopwatch_core; expected time, mode and display
// scan come from a seconds-count model and the segment table.
module tb_stopwatch_core;
  logic clk_25MHz = 1'b0;
  logic rst_n     = 1'b0;

  always #20 clk_25MHz = ~clk_25MHz;

  stopwatch_core_if bus ();

  stopwatch_core #(.DEBOUNCE_TICKS(20)) dut (
    .clk_25MHz (clk_25MHz),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  int checks   = 0;
  int failures = 0;

  int m_secs = 0;
  int m_mode = M_IDLE;
  int m_idx  = 0;

  logic [15:0] exp_q[$];
  logic [15:0] digits;
  assign digits = {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] bcd_of(input int s);
    int mm;
    int ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [3:0] an_of(input int i);
    case (i)
      0: return 4'b1110;
      1: return 4'b1101;
      2: return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_25MHz);
  endtask

  task automatic ms_tick();
    bus.clk_1kHz = 1'b1;
    cyc(2);
    bus.clk_1kHz = 1'b0;
    cyc(2);
    m_idx = (m_idx + 1) % 4;
  endtask

  task automatic hz_tick();
    bus.clk_1Hz = 1'b1;
    cyc(2 + int'($urandom_range(0, 2)));
    bus.clk_1Hz = 1'b0;
    cyc(3);
    if (m_mode == M_RUN) m_secs = (m_secs + 1) % 3600;
    exp_q.push_back(bcd_of(m_secs));
    check("digits_after_tick", 32'(digits), 32'(exp_q.pop_front()));
  endtask

  task automatic apply_press(input bit ss, input bit clr);
    case (m_mode)
      M_IDLE: begin
        if (clr)     m_secs = 0;
        else if (ss) m_mode = M_RUN;
      end
      M_RUN: begin
        if (ss) m_mode = M_PAUSE;
      end
      default: begin
        if (clr) begin
          m_mode = M_IDLE;
          m_secs = 0;
        end else if (ss) begin
          m_mode = M_RUN;
        end
      end
    endcase
  endtask

  task automatic release_buttons();
    bus.btn_start_stop = 1'b0;
    bus.btn_clear      = 1'b0;
    cyc(2);
    repeat (22) ms_tick();
    check("release_no_event", 32'(bus.running), 32'(m_mode == M_RUN));
  endtask

  // Holds the buttons for a random 21..28 ms; with_hz lines a 1 Hz tick up with the press.
  task automatic press(input bit ss, input bit clr, input bit with_hz);
    int hold;
    hold = int'($urandom_range(21, 28));
    bus.btn_start_stop = ss;
    bus.btn_clear      = clr;
    cyc(2);
    repeat (19) ms_tick();
    check("pre_accept_running", 32'(bus.running), 32'(m_mode == M_RUN));
    if (with_hz) begin
      bus.clk_1kHz = 1'b1;
      cyc(1);
      bus.clk_1Hz  = 1'b1;
      cyc(1);
      bus.clk_1kHz = 1'b0;
      cyc(2);
      bus.clk_1Hz  = 1'b0;
      cyc(3);
      m_idx = (m_idx + 1) % 4;
      if (m_mode == M_RUN) m_secs = (m_secs + 1) % 3600;
    end else begin
      ms_tick();
    end
    apply_press(ss, clr);
    check("post_accept_running", 32'(bus.running), 32'(m_mode == M_RUN));
    check("post_accept_digits", 32'(digits), 32'(bcd_of(m_secs)));
    for (int i = 20; i < hold; i++) ms_tick();
    release_buttons();
  endtask

  task automatic bounce_start();
    for (int s = 0; s < 10; s++) begin
      bus.btn_start_stop = (s % 2 == 0);
      cyc(2);
      repeat (5) ms_tick();
      check("bounce_no_event", 32'(bus.running), 32'(m_mode == M_RUN));
    end
    bus.btn_start_stop = 1'b1;
    cyc(2);
    repeat (19) ms_tick();
    check("bounce_tick19", 32'(bus.running), 32'(m_mode == M_RUN));
    ms_tick();
    apply_press(1'b1, 1'b0);
    check("bounce_tick20", 32'(bus.running), 32'(m_mode == M_RUN));
    release_buttons();
  endtask

  task automatic scan(input int n);
    logic [15:0] t;
    logic [3:0]  d;
    for (int i = 0; i < n; i++) begin
      bus.clk_1kHz = 1'b1;
      cyc(2);
      bus.clk_1kHz = 1'b0;
      cyc(1);
      check("scan_an_before", 32'(bus.an), 32'(an_of(m_idx)));
      m_idx = (m_idx + 1) % 4;
      cyc(1);
      t = bcd_of(m_secs);
      d = t[4*m_idx +: 4];
      check("scan_an", 32'(bus.an), 32'(an_of(m_idx)));
      check("scan_seg", 32'(bus.seg), 32'(seg_of(d)));
      cyc(1);
    end
  endtask

  task automatic reset_model();
    m_secs = 0;
    m_mode = M_IDLE;
    m_idx  = 0;
  endtask

  initial begin
    bus.clk_1Hz        = 1'b0;
    bus.clk_1kHz       = 1'b0;
    bus.btn_start_stop = 1'b0;
    bus.btn_clear      = 1'b0;
    rst_n = 1'b0;
    cyc(3);
    check("reset_seg", 32'(bus.seg), 32'h7f);
    check("reset_an", 32'(bus.an), 32'hf);
    check("reset_running", 32'(bus.running), 32'd0);
    check("reset_digits", 32'(digits), 32'h0);
    rst_n = 1'b1;
    reset_model();
    cyc(2);
    check("idle_an", 32'(bus.an), 32'(4'b1110));
    check("idle_seg", 32'(bus.seg), 32'(7'b1000000));

    // Basic run to 01:15.
    press(1'b1, 1'b0, 1'b0);
    repeat (75) hz_tick();
    check("basic_0115", 32'(digits), 32'h0115);
    check("basic_running", 32'(bus.running), 32'd1);

    press(1'b0, 1'b1, 1'b0);
    check("clear_while_running", 32'(digits), 32'h0115);

    press(1'b1, 1'b1, 1'b0);
    check("both_in_running_pauses", 32'(bus.running), 32'd0);
    repeat (int'($urandom_range(2, 5))) hz_tick();
    press(1'b1, 1'b1, 1'b0);
    check("both_in_paused_clears", 32'(digits), 32'h0000);
    press(1'b1, 1'b1, 1'b0);
    check("both_in_idle_stays", 32'(bus.running), 32'd0);

    // Pause at 00:07 on an edge that also carries a 1 Hz tick.
    press(1'b1, 1'b0, 1'b0);
    repeat (6) hz_tick();
    press(1'b1, 1'b0, 1'b1);
    check("pause_tick_counted", 32'(digits), 32'h0007);
    repeat (4) hz_tick();
    check("paused_hold", 32'(digits), 32'h0007);
    press(1'b1, 1'b0, 1'b1);
    check("resume_tick_dropped", 32'(digits), 32'h0007);
    repeat (int'($urandom_range(3, 20))) hz_tick();
    press(1'b1, 1'b0, 1'b0);
    press(0, 1'b1, 1'b0);
    check("clear_from_paused", 32'(digits), 32'h0000);
    check("clear_idle_running", 32'(bus.running), 32'd0);

    bounce_start();

    // Run from 00:00 through 3600 ticks, pausing at 12:34 to scan the display.
    repeat (754) hz_tick();
    check("time_1234", 32'(digits), 32'h1234);
    press(1'b1, 1'b0, 1'b0);
    scan(8);
    press(1'b1, 1'b0, 1'b0);
    repeat (3600 - 754) hz_tick();
    check("wrap_digits", 32'(digits), 32'h0000);
    check("wrap_running", 32'(bus.running), 32'd1);

    // Reset in the middle of a run.
    repeat (int'($urandom_range(5, 30))) hz_tick();
    rst_n = 1'b0;
    cyc(1);
    check("midreset_seg", 32'(bus.seg), 32'h7f);
    check("midreset_an", 32'(bus.an), 32'hf);
    check("midreset_running", 32'(bus.running), 32'd0);
    check("midreset_digits", 32'(digits), 32'h0);
    cyc(1);
    rst_n = 1'b1;
    reset_model();
    cyc(2);
    repeat (int'($urandom_range(2, 6))) hz_tick();
    press(1'b1, 1'b0, 1'b0);
    repeat (int'($urandom_range(5, 15))) hz_tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
